mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester arbiter in front of a single-port synchronous RAM
//
// Shares one single-port RAM between an instruction-fetch port and a data
// (load/store) port. One command is issued per cycle at most; the matching
// ready pulse arrives on the following cycle together with the RAM read data.
// The requester being answered is masked from arbitration, so the other port
// can use the RAM in the same cycle.
//
// Build option: define MEM_ARB_STARVE_GUARD_EN to add a saturating starvation
// counter that lets fetch win after STARVE_MAX consecutive eligible losses.
// Without it, data always has priority over fetch.
//
// Ports:
//   clock_i, clear_i       clock, asynchronous active-low reset
//   if_req_i, if_addr_i    fetch request and word address (held until ready)
//   if_rdata_o, if_ready_o fetch data and one-cycle completion pulse
//   d_req_i .. d_func3_i   data request, write enable, address, write data, size
//   d_rdata_o, d_ready_o   load data and one-cycle completion pulse
//   mem_*_o                RAM command (enable, write, address, data, size)
//   mem_rdata_i            RAM read data, valid one cycle after a read command
//   stall_if_o/stall_mem_o pipeline stall requests
module mem_arbiter #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clock_i,
   input  logic              clear_i,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [DATA_W-1:0] if_rdata_o,
   output logic              if_ready_o,
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   input  logic [2:0]        d_func3_i,
   output logic [DATA_W-1:0] d_rdata_o,
   output logic              d_ready_o,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   output logic [2:0]        mem_func3_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              stall_if_o,
   output logic              stall_mem_o
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RESP_IF = 2'd1,
      RESP_D  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] d_rdata_q;
   logic              if_elig;
   logic              d_elig;
   logic              fetch_first;
   logic              grant_if;
   logic              grant_d;

   if (STARVE_MAX < 1) begin : g_bad_starve_max
      $error("mem_arbiter: STARVE_MAX must be at least 1");
   end

`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam int                CNT_W   = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0]  CNT_TOP = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0] starve_q, starve_d;

   always_comb begin
      starve_d = starve_q;
      if (grant_if) begin
         starve_d = '0;
      end else if (grant_d && if_elig && (starve_q != CNT_TOP)) begin
         starve_d = starve_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clock_i or negedge clear_i) begin
      if (!clear_i) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end

   assign fetch_first = (starve_q == CNT_TOP);
`else
   assign fetch_first = 1'b0;
`endif

   // Arbitration. Gating with clear_i keeps the RAM idle while reset is held.
   always_comb begin
      if_elig  = clear_i & if_req_i & (state_q != RESP_IF);
      d_elig   = clear_i & d_req_i & (state_q != RESP_D);
      grant_if = if_elig & (~d_elig | fetch_first);
      grant_d  = d_elig & ~grant_if;

      if (grant_if) begin
         state_d = RESP_IF;
      end else if (grant_d) begin
         state_d = RESP_D;
      end else begin
         state_d = IDLE;
      end
   end

   // RAM command mux; fetches are always word reads.
   always_comb begin
      mem_en_o    = grant_if | grant_d;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_func3_o = 3'b000;
      if (grant_d) begin
         mem_we_o    = d_we_i;
         mem_addr_o  = d_addr_i;
         mem_wdata_o = d_wdata_i;
         mem_func3_o = d_func3_i;
      end else if (grant_if) begin
         mem_addr_o  = if_addr_i;
         mem_func3_o = 3'b010;
      end
   end

   // The rdata registers capture the RAM word during the response cycle so
   // the outputs keep showing it afterwards.
   always_ff @(posedge clock_i or negedge clear_i) begin
      if (!clear_i) begin
         state_q    <= IDLE;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == RESP_IF) begin
            if_rdata_q <= mem_rdata_i;
         end
         if (state_q == RESP_D) begin
            d_rdata_q <= mem_rdata_i;
         end
      end
   end

   assign if_ready_o  = (state_q == RESP_IF);
   assign d_ready_o   = (state_q == RESP_D);
   assign if_rdata_o  = if_ready_o ? mem_rdata_i : if_rdata_q;
   assign d_rdata_o   = d_ready_o ? mem_rdata_i : d_rdata_q;
   assign stall_if_o  = if_req_i & ~if_ready_o;
   assign stall_mem_o = d_req_i & ~d_ready_o;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

   localparam int AW   = 8;
   localparam int DW   = 32;
   localparam int SMAX = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          clear = 1'b0;
   logic          if_req = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic [DW-1:0] if_rdata;
   logic          if_ready;
   logic          d_req = 1'b0;
   logic          d_we = 1'b0;
   logic [AW-1:0] d_addr = '0;
   logic [DW-1:0] d_wdata = '0;
   logic [2:0]    d_func3 = 3'b000;
   logic [DW-1:0] d_rdata;
   logic          d_ready;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [2:0]    mem_func3;
   logic [DW-1:0] mem_rdata = '0;
   logic          stall_if;
   logic          stall_mem;

   always #5 clock = ~clock;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
      .clock_i(clock), .clear_i(clear),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_ready_o(if_ready),
      .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
      .d_func3_i(d_func3), .d_rdata_o(d_rdata), .d_ready_o(d_ready),
      .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
      .mem_func3_o(mem_func3), .mem_rdata_i(mem_rdata),
      .stall_if_o(stall_if), .stall_mem_o(stall_mem)
   );

   // Synchronous single-port RAM driven by the DUT's command.
   logic [DW-1:0] ram [256];
   always @(posedge clock) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata     <= ram[mem_addr];
      end
   end

   // Reference model: who is being answered this cycle, expected data,
   // a shadow copy of memory contents and the starvation count.
   int            checks = 0;
   int            errors = 0;
   int            ans = 0;          // 0 none, 1 fetch, 2 data
   int            g = 0;            // grant predicted for this cycle
   bit            ei = 1'b0;
   int            starve = 0;
   logic [DW-1:0] shadow [256];
   logic [DW-1:0] exp_if = '0, exp_d = '0, last_if = '0, last_d = '0, last_read = '0;
   bit            if_w = 1'b0, d_w = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_check();
      bit ed;
      ei = if_req && (ans != 1);
      ed = d_req && (ans != 2);
      if (ei && ed)  g = (GUARD && starve == SMAX) ? 1 : 2;
      else if (ei)   g = 1;
      else if (ed)   g = 2;
      else           g = 0;
      chk("mem_en", mem_en, g != 0);
      if (g == 1) begin
         chk("if_mem_addr", mem_addr, if_addr);
         chk("if_mem_we", mem_we, 0);
         chk("if_mem_func3", mem_func3, 3'b010);
      end else if (g == 2) begin
         chk("d_mem_addr", mem_addr, d_addr);
         chk("d_mem_we", mem_we, d_we);
         chk("d_mem_func3", mem_func3, d_func3);
         if (d_we) chk("d_mem_wdata", mem_wdata, d_wdata);
      end else begin
         chk("idle_mem_we", mem_we, 0);
      end
      chk("if_ready", if_ready, ans == 1);
      chk("d_ready", d_ready, ans == 2);
      chk("if_rdata", if_rdata, (ans == 1) ? exp_if : last_if);
      chk("d_rdata", d_rdata, (ans == 2) ? exp_d : last_d);
      chk("stall_if", stall_if, if_req && (ans != 1));
      chk("stall_mem", stall_mem, d_req && (ans != 2));
   endtask

   task automatic model_advance();
      if (ans == 1) last_if = exp_if;
      if (ans == 2) last_d = exp_d;
      if (g == 1) begin
         exp_if    = shadow[if_addr];
         last_read = exp_if;
      end else if (g == 2) begin
         if (d_we) begin
            shadow[d_addr] = d_wdata;
            exp_d = last_read;   // RAM output holds its last read word
         end else begin
            exp_d     = shadow[d_addr];
            last_read = exp_d;
         end
      end
      if (GUARD) begin
         if (g == 1) starve = 0;
         else if (g == 2 && ei && starve < SMAX) starve = starve + 1;
      end
      ans = g;
   endtask

   task automatic model_reset();
      ans = 0; starve = 0; last_if = '0; last_d = '0; g = 0;
   endtask

   task automatic tick();
      #1;
      model_check();
      model_advance();
      @(negedge clock);
   endtask

   typedef struct {
      logic          ir;
      logic [AW-1:0] ia;
      logic          dr;
      logic          dw;
      logic [AW-1:0] da;
      logic [DW-1:0] dd;
      logic [2:0]    df;
      logic          en;
      logic          we;
      logic [AW-1:0] addr;
      logic [2:0]    f3;
      logic          si;
      logic          sm;
   } vec_t;

   vec_t tbl [6];
   int   maxw, waitc, nf;

   initial begin
      tbl[0] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0,        3'd0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 8'h05, 1'b0, 1'b0, 8'h00, 32'h0,        3'd0, 1'b1, 1'b0, 8'h05, 3'd2, 1'b1, 1'b0};
      tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h20, 32'h0,        3'd4, 1'b1, 1'b0, 8'h20, 3'd4, 1'b0, 1'b1};
      tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h10, 32'hDEADBEEF, 3'd2, 1'b1, 1'b1, 8'h10, 3'd2, 1'b0, 1'b1};
      tbl[4] = '{1'b1, 8'h07, 1'b1, 1'b0, 8'h33, 32'h0,        3'd1, 1'b1, 1'b0, 8'h33, 3'd1, 1'b1, 1'b1};
      tbl[5] = '{1'b1, 8'h00, 1'b1, 1'b1, 8'hFF, 32'h12345678, 3'd0, 1'b1, 1'b1, 8'hFF, 3'd0, 1'b1, 1'b1};

      for (int i = 0; i < 256; i++) begin
         ram[i]    = $urandom;
         shadow[i] = ram[i];
      end

      // Reset held with both requests up: no command, reset values on outputs.
      if_req = 1'b1; d_req = 1'b1;
      repeat (2) @(negedge clock);
      #1;
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_if_ready", if_ready, 0);
      chk("rst_d_ready", d_ready, 0);
      chk("rst_if_rdata", if_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
      if_req = 1'b0; d_req = 1'b0;
      @(negedge clock);
      clear = 1'b1;
      model_reset();

      // Single-cycle decode from the idle state.
      for (int i = 0; i < 6; i++) begin
         if_req = tbl[i].ir; if_addr = tbl[i].ia;
         d_req = tbl[i].dr; d_we = tbl[i].dw; d_addr = tbl[i].da;
         d_wdata = tbl[i].dd; d_func3 = tbl[i].df;
         #1;
         chk($sformatf("tbl%0d_en", i), mem_en, tbl[i].en);
         chk($sformatf("tbl%0d_we", i), mem_we, tbl[i].we);
         if (tbl[i].en) begin
            chk($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].addr);
            chk($sformatf("tbl%0d_f3", i), mem_func3, tbl[i].f3);
         end
         chk($sformatf("tbl%0d_stall_if", i), stall_if, tbl[i].si);
         chk($sformatf("tbl%0d_stall_mem", i), stall_mem, tbl[i].sm);
         model_check();
         model_advance();
         @(negedge clock);
         if_req = 1'b0; d_req = 1'b0;
         tick();
         tick();
      end

      // Fetch only: RAM[5] returned one cycle after the grant.
      ram[5] = 32'h00A00093; shadow[5] = 32'h00A00093;
      if_req = 1'b1; if_addr = 8'h05;
      #1;
      chk("f_en", mem_en, 1); chk("f_addr", mem_addr, 8'h05); chk("f_we", mem_we, 0);
      model_check(); model_advance(); @(negedge clock);
      #1;
      chk("f_ready", if_ready, 1); chk("f_rdata", if_rdata, 32'h00A00093);
      model_check(); model_advance(); @(negedge clock);
      if_req = 1'b0;
      tick();

      // Simultaneous: store wins, fetch granted while data is answered.
      if_req = 1'b1; if_addr = 8'h03;
      d_req = 1'b1; d_we = 1'b1; d_addr = 8'h10; d_wdata = 32'hDEADBEEF; d_func3 = 3'b010;
      #1;
      chk("s_we", mem_we, 1); chk("s_addr", mem_addr, 8'h10);
      model_check(); model_advance(); @(negedge clock);
      #1;
      chk("s_d_ready", d_ready, 1); chk("s_if_en", mem_en, 1);
      chk("s_if_addr", mem_addr, 8'h03); chk("s_if_we", mem_we, 0);
      model_check(); model_advance(); @(negedge clock);
      d_req = 1'b0;
      #1;
      chk("s_if_ready", if_ready, 1);
      model_check(); model_advance(); @(negedge clock);
      if_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 8'h10;
      tick();
      #1;
      chk("s_readback", d_rdata, 32'hDEADBEEF);
      model_check(); model_advance(); @(negedge clock);
      d_req = 1'b0;
      tick();

      // Reset between a load grant and its response.
      d_req = 1'b1; d_we = 1'b0; d_addr = 8'h20; d_func3 = 3'b010;
      #1;
      chk("r_grant", mem_en, 1);
      model_check(); model_advance();
      clear = 1'b0;
      model_reset();
      @(negedge clock);
      #1;
      chk("r_d_ready_in_rst", d_ready, 0);
      chk("r_mem_en_in_rst", mem_en, 0);
      chk("r_d_rdata_in_rst", d_rdata, 0);
      clear = 1'b1;
      #1;
      chk("r_d_ready_after", d_ready, 0);
      chk("r_stall_mem_after", stall_mem, 1);
      model_check(); model_advance(); @(negedge clock);
      tick();
      d_req = 1'b0;
      tick();

      // Both ports requesting continuously: fetch never waits more than one cycle.
      maxw = 0; waitc = 0; nf = 0;
      for (int c = 0; c < 20; c++) begin
         if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
         if (ans == 2) d_addr = 8'($urandom_range(15, 0));
         if (ans == 1) if_addr = 8'($urandom_range(15, 0));
         #1;
         model_check();
         if (ei && g != 1) waitc++;
         if (g == 1) begin
            if (waitc > maxw) maxw = waitc;
            waitc = 0;
            nf++;
         end
         model_advance();
         @(negedge clock);
      end
      chk("starve_max_wait", maxw, 1);
      chk("starve_fetch_grants", nf, 10);
      if_req = 1'b0; d_req = 1'b0;
      tick();
      tick();

      // Randomized traffic against the model.
      if_w = 1'b0; d_w = 1'b0;
      for (int c = 0; c < 800; c++) begin
         if (ans == 1) begin
            if ($urandom_range(1, 0) == 0) if_req = 1'b0;
            if_w = 1'b0;
         end else if (if_w) begin
            if ($urandom_range(15, 0) == 0) begin if_req = 1'b0; if_w = 1'b0; end
         end else if ($urandom_range(1, 0) == 1) begin
            if_req = 1'b1; if_addr = 8'($urandom_range(15, 0)); if_w = 1'b1;
         end else begin
            if_req = 1'b0;
         end
         if (ans == 2) begin
            if ($urandom_range(1, 0) == 0) d_req = 1'b0;
            d_w = 1'b0;
         end else if (d_w) begin
            if ($urandom_range(15, 0) == 0) begin d_req = 1'b0; d_w = 1'b0; end
         end else if ($urandom_range(2, 0) != 0) begin
            d_req = 1'b1; d_we = 1'($urandom_range(1, 0));
            d_addr = 8'($urandom_range(15, 0)); d_wdata = $urandom;
            d_func3 = 3'($urandom_range(7, 0)); d_w = 1'b1;
         end else begin
            d_req = 1'b0;
         end
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
